// File: rtl/alu_issue_queue.sv
// alu_issue_queue: request FIFO in front of an external combinational ALU,
// with a registered, handshaked result stage. Issues one op per clock.
module alu_issue_queue #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  input  logic [2:0]                 in_sel,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output logic [2:0]                 alu_sel,
  input  logic [WIDTH-1:0]           alu_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_result,
  output logic [2:0]                 out_sel,
  output logic                       out_zero,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  // FIFO storage and bookkeeping
  logic [WIDTH-1:0] mem_a_q   [DEPTH];
  logic [WIDTH-1:0] mem_b_q   [DEPTH];
  logic [2:0]       mem_sel_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    level_q,  level_d;

  // Result register
  logic             out_valid_q,   out_valid_d;
  logic [WIDTH-1:0] out_result_q,  out_result_d;
  logic [2:0]       out_sel_q,     out_sel_d;
  logic             out_zero_q,    out_zero_d;
  logic             out_illegal_q, out_illegal_d;

  logic fifo_empty;
  logic push, pop;

  assign fifo_empty = (level_q == '0);
  // Ready comes only from the registered level, so a full FIFO refuses a push
  // even if the head pops in the same cycle (no out_ready -> in_ready path).
  assign in_ready   = (level_q != FULL_LVL);
  assign push       = in_valid && in_ready;
  assign pop        = !fifo_empty && (!out_valid_q || out_ready);

  // Head of FIFO feeds the ALU; zeros when empty so the ALU sees a quiet input.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = '0;
    if (!fifo_empty) begin
      alu_a   = mem_a_q[rd_ptr_q];
      alu_b   = mem_b_q[rd_ptr_q];
      alu_sel = mem_sel_q[rd_ptr_q];
    end
  end

  // Next-state for pointers, occupancy and the result register
  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    level_d       = level_q;
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_sel_d     = out_sel_q;
    out_zero_d    = out_zero_q;
    out_illegal_d = out_illegal_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (!push && pop) level_d = level_q - LW'(1);

    if (pop) begin
      out_valid_d   = 1'b1;
      out_result_d  = alu_out;
      out_sel_d     = alu_sel;
      out_zero_d    = (alu_out == '0);
      out_illegal_d = (alu_sel >= 3'b101);
    end else if (out_valid_q && out_ready) begin
      // Consumer took the last result and nothing is queued: drop valid, keep data.
      out_valid_d = 1'b0;
    end
  end

  // Control and result state; reset wins over any handshake in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      level_q       <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_sel_q     <= '0;
      out_zero_q    <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      level_q       <= level_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_sel_q     <= out_sel_d;
      out_zero_q    <= out_zero_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  // Payload storage needs no reset: entries are only read while level != 0
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_a_q[wr_ptr_q]   <= in_a;
      mem_b_q[wr_ptr_q]   <= in_b;
      mem_sel_q[wr_ptr_q] <= in_sel;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_sel     = out_sel_q;
  assign out_zero    = out_zero_q;
  assign out_illegal = out_illegal_q;
  assign level       = level_q;

endmodule
